// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
package tdm_pkg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_LAST = SLOT_W'(NCH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux4_if.sv
// TDM stream in, demultiplexed channels and status pulses out.
interface tdm_demux4_if #(
    parameter int unsigned WIDTH = 3
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             frame_valid;
    logic             sync_err;

    modport master (
        output din, din_valid, sync,
        input  a, b, c, d, frame_valid, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output a, b, c, d, frame_valid, sync_err
    );

endinterface : tdm_demux4_if

// File: rtl/tdm_slot_cnt.sv
// Frame slot counter: load1 restarts at slot 1, inc advances and wraps 3 -> 0.
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  load1,
    output slot_t slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + SLOT_W'(1);
        end
    end

endmodule : tdm_slot_cnt

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with sync-based frame alignment; channel outputs
// update atomically only when a complete frame has been received.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    slot_t            slot;
    slot_t            wr_idx;
    logic             inc;
    logic             load1;
    logic             sh_we;
    logic             out_ld;
    logic             fv_d;
    logic             err_d;

    logic [WIDTH-1:0] sh0_q;
    logic [WIDTH-1:0] sh1_q;
    logic [WIDTH-1:0] sh2_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic             fv_q;
    logic             err_q;

    tdm_slot_cnt u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .load1 (load1),
        .slot  (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; idle beats leave everything holding.
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        load1   = 1'b0;
        sh_we   = 1'b0;
        out_ld  = 1'b0;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        wr_idx  = bus.sync ? '0 : slot;
        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        sh_we   = 1'b1;
                        load1   = 1'b1;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (bus.sync) begin
                        // Early sync aborts the partial frame and restarts at slot 0.
                        err_d = (slot != '0);
                        sh_we = 1'b1;
                        load1 = 1'b1;
                    end else if (slot == '0) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (slot == SLOT_LAST) begin
                        out_ld = 1'b1;
                        fv_d   = 1'b1;
                        inc    = 1'b1;
                    end else begin
                        sh_we = 1'b1;
                        inc   = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Shadow slots 0..2 collect the frame until the slot-3 beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh0_q <= '0;
            sh1_q <= '0;
            sh2_q <= '0;
        end else if (sh_we) begin
            case (wr_idx)
                SLOT_W'(0): sh0_q <= bus.din;
                SLOT_W'(1): sh1_q <= bus.din;
                SLOT_W'(2): sh2_q <= bus.din;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            fv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            fv_q  <= fv_d;
            err_q <= err_d;
            if (out_ld) begin
                a_q <= sh0_q;
                b_q <= sh1_q;
                c_q <= sh2_q;
                d_q <= bus.din;
            end
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.c           = c_q;
    assign bus.d           = d_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = err_q;

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus randomized traffic
// compared every cycle against a queue-based frame model.
module tb_tdm_demux4;

    localparam int unsigned W   = 3;
    localparam int unsigned NCH = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    bit   chk_en;
    int   cyc;
    int   fv_cnt;
    int   fv_times[$];

    // reference model state
    bit             aligned;
    logic [W-1:0]   q[$];
    logic [W-1:0]   exp_a, exp_b, exp_c, exp_d;
    logic           exp_fv, exp_err;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: collect beats of an aligned frame; a fourth beat publishes it.
    always @(negedge rst_n) begin
        aligned = 1'b0;
        q.delete();
        {exp_a, exp_b, exp_c, exp_d} = '0;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            exp_fv  = 1'b0;
            exp_err = 1'b0;
            if (bus.din_valid === 1'b1) begin
                if (bus.sync) begin
                    if (aligned && q.size() != 0) exp_err = 1'b1;
                    q.delete();
                    q.push_back(bus.din);
                    aligned = 1'b1;
                end else if (aligned) begin
                    if (q.size() == 0) begin
                        exp_err = 1'b1;
                        aligned = 1'b0;
                    end else begin
                        q.push_back(bus.din);
                        if (q.size() == NCH) begin
                            exp_a  = q[0];
                            exp_b  = q[1];
                            exp_c  = q[2];
                            exp_d  = q[3];
                            exp_fv = 1'b1;
                            q.delete();
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_a", 32'(bus.a), 32'(exp_a));
            chk("cyc_b", 32'(bus.b), 32'(exp_b));
            chk("cyc_c", 32'(bus.c), 32'(exp_c));
            chk("cyc_d", 32'(bus.d), 32'(exp_d));
            chk("cyc_fv", 32'(bus.frame_valid), 32'(exp_fv));
            chk("cyc_err", 32'(bus.sync_err), 32'(exp_err));
            chk("cyc_excl", 32'(bus.frame_valid & bus.sync_err), 32'(0));
            if (bus.frame_valid === 1'b1) begin
                fv_cnt++;
                fv_times.push_back(cyc);
            end
        end
    end

    task automatic beat(input logic [W-1:0] v, input logic s);
        bus.din       = v;
        bus.sync      = s;
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    // Idle cycles carry random junk on din/sync that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.din       = W'($urandom);
            bus.sync      = 1'($urandom);
            bus.din_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic [W-1:0] ec, input logic [W-1:0] ed);
        chk({name, "_a"}, 32'(bus.a), 32'(ea));
        chk({name, "_b"}, 32'(bus.b), 32'(eb));
        chk({name, "_c"}, 32'(bus.c), 32'(ec));
        chk({name, "_d"}, 32'(bus.d), 32'(ed));
    endtask

    initial begin
        int n0;
        tests = 0; fails = 0; chk_en = 1'b0; cyc = 0; fv_cnt = 0;
        aligned = 1'b0;
        {exp_a, exp_b, exp_c, exp_d} = '0;
        exp_fv = 1'b0; exp_err = 1'b0;
        bus.din = '0; bus.sync = 1'b0; bus.din_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("rst", 3'b000, 3'b000, 3'b000, 3'b000);
        chk("rst_fv", 32'(bus.frame_valid), 32'(0));
        chk("rst_err", 32'(bus.sync_err), 32'(0));
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(1);

        // basic frame
        beat(3'b001, 1'b1); beat(3'b011, 1'b0); beat(3'b101, 1'b0);
        chk("r27_fv_early", 32'(bus.frame_valid), 32'(0));
        beat(3'b110, 1'b0);
        chk("r27_fv", 32'(bus.frame_valid), 32'(1));
        chk_out("r27", 3'b001, 3'b011, 3'b101, 3'b110);
        idle(1);
        chk("r27_fv_once", 32'(bus.frame_valid), 32'(0));

        // back-to-back frames
        beat(3'b001, 1'b1); beat(3'b011, 1'b0); beat(3'b101, 1'b0); beat(3'b110, 1'b0);
        beat(3'b110, 1'b1); beat(3'b101, 1'b0); beat(3'b011, 1'b0); beat(3'b001, 1'b0);
        idle(1);
        chk_out("r28", 3'b110, 3'b101, 3'b011, 3'b001);
        chk("r28_gap", 32'(fv_times[fv_times.size()-1] - fv_times[fv_times.size()-2]), 32'(4));

        // frame with valid gaps
        n0 = fv_cnt;
        beat(3'b001, 1'b1); idle(2); beat(3'b011, 1'b0); idle(2);
        beat(3'b101, 1'b0); idle(2); beat(3'b110, 1'b0); idle(2);
        chk_out("r29", 3'b001, 3'b011, 3'b101, 3'b110);
        chk("r29_npulse", 32'(fv_cnt - n0), 32'(1));

        // early sync aborts partial frame
        beat(3'b001, 1'b1); beat(3'b011, 1'b0); beat(3'b101, 1'b1);
        chk("r30_err", 32'(bus.sync_err), 32'(1));
        chk_out("r30_hold", 3'b001, 3'b011, 3'b101, 3'b110);
        beat(3'b111, 1'b0); beat(3'b000, 1'b0); beat(3'b010, 1'b0);
        chk("r30_fv", 32'(bus.frame_valid), 32'(1));
        chk_out("r30", 3'b101, 3'b111, 3'b000, 3'b010);

        // missing sync at slot 0 drops to HUNT
        beat(3'b100, 1'b0);
        chk("r31_err", 32'(bus.sync_err), 32'(1));
        n0 = fv_cnt;
        beat(3'b001, 1'b0); beat(3'b010, 1'b0); beat(3'b011, 1'b0); beat(3'b100, 1'b0);
        idle(1);
        chk("r31_nofv", 32'(fv_cnt - n0), 32'(0));
        chk_out("r31_hold", 3'b101, 3'b111, 3'b000, 3'b010);
        beat(3'b011, 1'b1); beat(3'b010, 1'b0); beat(3'b001, 1'b0); beat(3'b000, 1'b0);
        chk_out("r31", 3'b011, 3'b010, 3'b001, 3'b000);

        // asynchronous reset mid-frame
        beat(3'b001, 1'b1); beat(3'b010, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("r32_async", 3'b000, 3'b000, 3'b000, 3'b000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        n0 = fv_cnt;
        beat(3'b011, 1'b0); beat(3'b100, 1'b0); beat(3'b101, 1'b0); beat(3'b110, 1'b0);
        idle(1);
        chk("r32_nofv", 32'(fv_cnt - n0), 32'(0));
        beat(3'b111, 1'b1); beat(3'b110, 1'b0); beat(3'b101, 1'b0); beat(3'b100, 1'b0);
        chk_out("r32", 3'b111, 3'b110, 3'b101, 3'b100);

        // randomized traffic, including rare asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
            end else if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                beat(W'($urandom), 1'($urandom_range(0, 5) == 0));
            end
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_tdm_demux4

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of each channel and of the TDM data stream.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port din, input, WIDTH: TDM data beat.
REQ-005 SHALL have port din_valid, input, 1: din carries a beat this cycle.
REQ-006 SHALL have port sync, input, 1: qualified by din_valid; marks slot 0, the start of a frame.
REQ-007 SHALL have ports a, b, c, d, output, WIDTH each: registered channel values for slots 0, 1, 2 and 3.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse when a..d have just been updated.
REQ-009 SHALL have port sync_err, output, 1: one-cycle pulse when a framing violation is detected.

Function
REQ-010 SHALL implement a two-state FSM: HUNT (no frame alignment) and RECV (aligned).
REQ-011 SHALL ignore all inputs in any cycle where din_valid=0; state, slot counter and shadow registers hold.
REQ-012 In HUNT, a beat with sync=0 SHALL be discarded with no sync_err.
REQ-013 In HUNT, a beat with sync=1 SHALL be stored as slot 0 and set slot=1; state SHALL go to RECV.
REQ-014 In RECV, a beat with sync=0 at slot 1 or 2 SHALL be stored to the shadow register for that slot, and slot SHALL increment.
REQ-015 In RECV, a beat with sync=0 at slot 3 SHALL load a..d together from shadow slots 0..2 and din, on that same edge; slot SHALL wrap to 0 and state SHALL stay RECV.
REQ-016 frame_valid SHALL be 1 for exactly the cycle following the edge that loads a..d; latency from the slot-3 beat to frame_valid is 1 cycle.
REQ-017 In RECV, a beat at slot 0 with sync=1 SHALL be accepted as a new frame start, identical to REQ-013.
REQ-018 In RECV, a beat at slot 0 with sync=0 SHALL pulse sync_err, SHALL be discarded, and state SHALL go to HUNT.
REQ-019 In RECV, a beat with sync=1 at slot 1, 2 or 3 SHALL pulse sync_err, discard the partial frame (a..d unchanged), and restart as slot 0 with slot=1 in RECV.
REQ-020 a..d SHALL change only per REQ-015; partial or aborted frames SHALL never be visible on a..d.
REQ-021 sync_err and frame_valid SHALL never be asserted in the same cycle.
REQ-022 Back-to-back frames with din_valid=1 every cycle SHALL sustain one frame per 4 cycles with no beat lost.

Reset
REQ-023 rst_n=0 SHALL immediately force: state=HUNT, slot=0, a=b=c=d=0, shadow registers=0, frame_valid=0, sync_err=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; after release, the first beat SHALL be treated per REQ-012/REQ-013.

Structure
REQ-025 Package tdm_pkg SHALL hold the state enum (HUNT, RECV), the 2-bit slot type and the NCH=4 constant.
REQ-026 The slot counter with wrap SHALL be a sub-module named tdm_slot_cnt (inputs: inc, load1; output: slot); all other logic SHALL be in tdm_demux4.

Verification
REQ-027 Reset, then beats 001(sync),011,101,110 on consecutive cycles -> a=001, b=011, c=101, d=110; frame_valid pulses 1 cycle after the 110 beat.
REQ-028 Two back-to-back frames, the second being 110(sync),101,011,001 -> two frame_valid pulses 4 cycles apart; final a=110, d=001.
REQ-029 Frame with din_valid=0 gaps of 2 cycles between beats -> same a..d as REQ-027; a single frame_valid pulse.
REQ-030 001(sync),011, then 101 with sync=1 -> sync_err pulse; a..d unchanged; then 111,000,010 complete the frame -> a=101, b=111, c=000, d=010.
REQ-031 After a complete frame, a slot-0 beat without sync -> sync_err and HUNT; subsequent beats without sync are ignored until the next sync.
REQ-032 rst_n pulsed low after 2 beats of a frame -> all outputs 0 asynchronously; no frame_valid until a fresh full frame arrives.
